axil_mem_tester: RTL and testbench
==================================

AXIL_MEM_TESTER -- requirements
Module: axil_mem_tester

Interface
REQ-001 The block SHALL have parameter N_WORDS, default 16, number of 32-bit words tested (1..65535).
REQ-002 The block SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 The block SHALL have parameter SEED, default 32'hACE1_2024, LFSR start value (nonzero).
REQ-004 The block SHALL have port clk  input  1  sole clock.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port axi_if  taxi_axil_if.man  32-bit addr/data  AXI-Lite manager toward axil_sdram.
REQ-007 The block SHALL have port start  input  1  one-cycle request to run a test.
REQ-008 The block SHALL have port busy  output  1  test in progress.
REQ-009 The block SHALL have port done  output  1  test finished; held until next accepted start.
REQ-010 The block SHALL have port pass  output  1  done and err_count==0.
REQ-011 The block SHALL have port err_count  output  16  mismatches plus non-OKAY responses, saturating at 16'hFFFF.
REQ-012 The block SHALL have port first_err_addr  output  32  byte address of first error; 0 if none.

Function
REQ-013 States SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; elsewhere ignored. Acceptance clears done, pass, err_count, first_err_addr, index i, and loads LFSR=SEED; next state WR_REQ.
REQ-015 Word i address SHALL be ADDR_BASE + (i<<2), modulo 2^32; data SHALL be the i-th LFSR value (word 0 = SEED).
REQ-016 LFSR SHALL be 32-bit Galois, shift right, XOR mask 32'h8020_0003 applied when the shifted-out bit is 1; it advances once per completed word.
REQ-017 WR_REQ SHALL assert awvalid and wvalid together, wstrb=4'hF, awprot=0. Each valid drops the cycle after its own handshake. Address and data stay stable while valid. On both handshakes done, go to WR_RESP.
REQ-018 WR_RESP SHALL hold bready=1. On bvalid: bresp!=OKAY counts one error. Then advance i. Go to WR_REQ, or to RD_REQ after word N_WORDS-1 with i=0 and LFSR=SEED.
REQ-019 RD_REQ SHALL assert arvalid with arprot=0 until arready, then go to RD_RESP.
REQ-020 RD_RESP SHALL hold rready=1. On rvalid, rdata!=expected or rresp!=OKAY counts one error, even if both fail. Then advance i. Go to RD_REQ, or to DONE after the last word.
REQ-021 Only one AXI transaction SHALL be outstanding. bready and rready SHALL be low outside their response states.
REQ-022 first_err_addr SHALL latch on the first error only, when err_count goes from 0 to 1.
REQ-023 Err_count SHALL saturate at 16'hFFFF and never wrap.
REQ-024 In DONE: busy=0, done=1, pass=(err_count==0). busy SHALL be 1 in WR_REQ..RD_RESP.
REQ-025 There SHALL be no timeout: a silent slave holds the FSM in its current state.

Reset
REQ-026 While rst=1, state SHALL be IDLE and all AXI valid/ready outputs, busy, done, pass, err_count and first_err_addr SHALL be 0 at the next clk edge.
REQ-027 Reset mid-transaction SHALL abandon the transaction without completing it. The first start after rst deasserts SHALL run a full fresh test.

Structure
REQ-028 Package axil_mem_tester_pkg SHALL hold the state enum, LFSR_MASK=32'h8020_0003, and AXI_RESP_OKAY=2'b00.
REQ-029 LFSR step SHALL be a sub-module lfsr32 (clk, rst, load, load_val, step, value).
REQ-030 The datapath SHALL be one FSM plus index counter, LFSR, error counter and first-error register.

Verification
REQ-031 N_WORDS=4, ready slave with 0 wait states, start pulse -> writes to 0x0,0x4,0x8,0xC with data SEED, L1, L2, L3 in order. Reads follow in the same order. Then done=1, pass=1, err_count=0.
REQ-032 Same run, slave flips rdata bit0 at 0x8 -> err_count=1, first_err_addr=0x8, pass=0.
REQ-033 awready delayed 3 cycles, wready immediate -> wvalid high exactly one handshake cycle, awvalid held 4 cycles with stable awaddr, exactly 4 writes total in the slave.
REQ-034 bresp=SLVERR on word 1 and rdata mismatch at 0xC -> err_count=2, first_err_addr=0x4.
REQ-035 start pulsed during RD_REQ -> ignored, no counter change. start pulsed in DONE -> fresh test, err_count cleared.
REQ-036 rst asserted in RD_RESP -> next cycle all outputs 0, state IDLE. A subsequent start -> full pass with a correct slave.

Source files
------------

// File: rtl/axil_mem_tester_pkg.sv
// AXI-Lite memory tester shared types.
// State encoding, LFSR mask and response codes.
package axil_mem_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] v
  );
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// 32-bit AXI-Lite bundle.
// man drives requests, sub answers them.
interface taxi_axil_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport man (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport sub (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axil_mem_tester_lfsr32.sv
// 32-bit Galois LFSR, right shift.
// load takes priority over step.
import axil_mem_tester_pkg::*;

module lfsr32 #(
  parameter logic [31:0] RST_VAL = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/axil_mem_tester.sv
// Writes an LFSR pattern over AXI-Lite,
// reads it back and counts errors.
import axil_mem_tester_pkg::*;

module axil_mem_tester #(
  parameter int unsigned N_WORDS   = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] SEED      = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axil_if.man    axi_if,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr
);

  localparam logic [15:0] LAST = 16'(N_WORDS - 1);

  state_t      state;
  logic [15:0] idx;
  logic [31:0] lfsr_q;
  logic [31:0] addr;
  logic        awv, wv, bre, arv, rre;
  logic        last, go, b_hs, r_hs;
  logic        err_hit, lfsr_load, lfsr_step;
  logic        aw_ok, w_ok;

  assign addr = ADDR_BASE + {14'd0, idx, 2'b00};
  assign last = idx == LAST;
  assign go   = start && (state == IDLE || state == DONE);
  assign b_hs = state == WR_RESP && axi_if.bvalid;
  assign r_hs = state == RD_RESP && axi_if.rvalid;
  assign aw_ok = !awv || axi_if.awready;
  assign w_ok  = !wv || axi_if.wready;

  assign err_hit =
    (b_hs && axi_if.bresp != AXI_RESP_OKAY) ||
    (r_hs && (axi_if.rdata != lfsr_q ||
              axi_if.rresp != AXI_RESP_OKAY));

  // The read pass replays the write sequence from SEED.
  assign lfsr_load = go || (b_hs && last);
  assign lfsr_step = (b_hs || r_hs) && !lfsr_load;

  lfsr32 #(.RST_VAL(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (SEED),
    .step     (lfsr_step),
    .value    (lfsr_q)
  );

  assign axi_if.awaddr  = addr;
  assign axi_if.awprot  = 3'b000;
  assign axi_if.awvalid = awv;
  assign axi_if.wdata   = lfsr_q;
  assign axi_if.wstrb   = 4'hF;
  assign axi_if.wvalid  = wv;
  assign axi_if.bready  = bre;
  assign axi_if.araddr  = addr;
  assign axi_if.arprot  = 3'b000;
  assign axi_if.arvalid = arv;
  assign axi_if.rready  = rre;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      awv            <= 1'b0;
      wv             <= 1'b0;
      bre            <= 1'b0;
      arv            <= 1'b0;
      rre            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (err_hit) begin
        if (err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
        if (err_count == 16'd0)
          first_err_addr <= addr;
      end
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state          <= WR_REQ;
            idx            <= '0;
            awv            <= 1'b1;
            wv             <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        WR_REQ: begin
          if (axi_if.awready) awv <= 1'b0;
          if (axi_if.wready) wv <= 1'b0;
          if (aw_ok && w_ok) begin
            state <= WR_RESP;
            bre   <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bre <= 1'b0;
            if (last) begin
              idx   <= '0;
              arv   <= 1'b1;
              state <= RD_REQ;
            end else begin
              idx   <= idx + 16'd1;
              awv   <= 1'b1;
              wv    <= 1'b1;
              state <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (axi_if.arready) begin
            arv   <= 1'b0;
            rre   <= 1'b1;
            state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            rre <= 1'b0;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= err_count == 16'd0 && !err_hit;
              state <= DONE;
            end else begin
              idx   <= idx + 16'd1;
              arv   <= 1'b1;
              state <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_mem_tester.sv
// Randomized bench for axil_mem_tester
// against a memory slave and word-level model.
module tb_axil_mem_tester;

  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] MASK = 32'h8020_0003;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  taxi_axil_if axi ();

  axil_mem_tester #(
    .N_WORDS   (NW),
    .ADDR_BASE (32'h0),
    .SEED      (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axi_if         (axi),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [3:0] bmask = '0;
  logic [3:0] fmask = '0;
  logic [3:0] rmask = '0;
  int aw_dly = 0;
  int ar_dly = 0;
  logic rd_silent = 1'b0;
  logic clr = 1'b0;

  logic [31:0] mem [16];
  logic [31:0] wr_a [$];
  logic [31:0] wr_d [$];
  logic [31:0] rd_a [$];
  int aw_cnt, ar_cnt;
  int awv_cyc, wv_cyc, arv_cyc;
  int unstable, overlap;
  logic aw_got, w_got, ar_pend;
  logic [31:0] aw_lat, w_lat, ar_lat;
  logic prev_awv, prev_wv;
  logic [31:0] prev_awaddr, prev_wdata;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
  assign axi.wready  = 1'b1;
  assign axi.arready = axi.arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk) begin
    if (clr) begin
      wr_a.delete();
      wr_d.delete();
      rd_a.delete();
      awv_cyc  <= 0;
      wv_cyc   <= 0;
      arv_cyc  <= 0;
      unstable <= 0;
      overlap  <= 0;
    end else begin
      if (axi.awvalid) awv_cyc <= awv_cyc + 1;
      if (axi.wvalid) wv_cyc <= wv_cyc + 1;
      if (axi.arvalid) arv_cyc <= arv_cyc + 1;
      if ((axi.awvalid && prev_awv && axi.awaddr != prev_awaddr) ||
          (axi.wvalid && prev_wv && axi.wdata != prev_wdata))
        unstable <= unstable + 1;
      if ((axi.bready && (axi.awvalid || axi.wvalid ||
                          axi.arvalid || axi.rready)) ||
          (axi.rready && (axi.awvalid || axi.wvalid || axi.arvalid)) ||
          (axi.arvalid && (axi.awvalid || axi.wvalid)))
        overlap <= overlap + 1;
      if (axi.awvalid && axi.awready) wr_a.push_back(axi.awaddr);
      if (axi.wvalid && axi.wready) wr_d.push_back(axi.wdata);
      if (axi.arvalid && axi.arready) rd_a.push_back(axi.araddr);
    end
    prev_awv    <= axi.awvalid;
    prev_wv     <= axi.wvalid;
    prev_awaddr <= axi.awaddr;
    prev_wdata  <= axi.wdata;
    aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
    ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
    if (rst) begin
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      ar_pend    <= 1'b0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      axi.rresp  <= 2'b00;
      axi.rdata  <= '0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        aw_got <= 1'b1;
        aw_lat <= axi.awaddr;
      end
      if (axi.wvalid && axi.wready) begin
        w_got <= 1'b1;
        w_lat <= axi.wdata;
      end
      if (aw_got && w_got && !axi.bvalid) begin
        mem[aw_lat[5:2]] <= w_lat;
        axi.bvalid <= 1'b1;
        axi.bresp  <= bmask[aw_lat[3:2]] ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        ar_pend <= 1'b1;
        ar_lat  <= axi.araddr;
      end
      if (ar_pend && !axi.rvalid && !rd_silent) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= mem[ar_lat[5:2]] ^
                      (fmask[ar_lat[3:2]] ? 32'h1 : 32'h0);
        axi.rresp  <= rmask[ar_lat[3:2]] ? 2'b10 : 2'b00;
        ar_pend <= 1'b0;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] v);
    logic [31:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ MASK;
    return n;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 2000 && !done; c++) @(negedge clk);
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_run(input string tag);
    logic [31:0] v;
    logic [31:0] exp_first;
    int exp_err;
    logic [3:0] rerr;
    v = SEED;
    rerr = fmask | rmask;
    exp_err = $countones(bmask) + $countones(rerr);
    exp_first = 32'h0;
    for (int k = NW - 1; k >= 0; k--)
      if (rerr[k]) exp_first = 32'(k * 4);
    for (int k = NW - 1; k >= 0; k--)
      if (bmask[k]) exp_first = 32'(k * 4);
    check({tag, "_nwr"}, 32'(wr_a.size()), NW);
    check({tag, "_nwd"}, 32'(wr_d.size()), NW);
    check({tag, "_nrd"}, 32'(rd_a.size()), NW);
    for (int k = 0; k < NW; k++) begin
      check({tag, "_wa"}, k < wr_a.size() ? wr_a[k] : 'x, 32'(k * 4));
      check({tag, "_wd"}, k < wr_d.size() ? wr_d[k] : 'x, v);
      check({tag, "_ra"}, k < rd_a.size() ? rd_a[k] : 'x, 32'(k * 4));
      v = ref_next(v);
    end
    check({tag, "_err"}, {16'd0, err_count}, 32'(exp_err));
    check({tag, "_first"}, first_err_addr, exp_first);
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_err == 0});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_awcyc"}, 32'(awv_cyc), 32'(NW * (aw_dly + 1)));
    check({tag, "_wcyc"}, 32'(wv_cyc), NW);
    check({tag, "_arcyc"}, 32'(arv_cyc), 32'(NW * (ar_dly + 1)));
    check({tag, "_stable"}, 32'(unstable), 0);
    check({tag, "_overlap"}, 32'(overlap), 0);
  endtask

  task automatic run(input string tag,
                     input logic [3:0] b, input logic [3:0] f,
                     input logic [3:0] r, input int awd,
                     input int ard);
    bmask = b;
    fmask = f;
    rmask = r;
    aw_dly = awd;
    ar_dly = ard;
    pulse_start();
    wait_done();
    check_run(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_axi"},
          {27'd0, axi.awvalid, axi.wvalid, axi.bready,
           axi.arvalid, axi.rready}, 32'd0);
    check({tag, "_flags"}, {29'd0, busy, done, pass}, 32'd0);
    check({tag, "_err"}, {16'd0, err_count}, 32'd0);
    check({tag, "_first"}, first_err_addr, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run("clean", 4'h0, 4'h0, 4'h0, 0, 0);
    run("flip8", 4'h0, 4'h4, 4'h0, 0, 0);
    run("awdly3", 4'h0, 4'h0, 4'h0, 3, 0);
    run("slverr", 4'h2, 4'h8, 4'h0, 0, 0);

    bmask = 4'h0; fmask = 4'h0; rmask = 4'h0;
    aw_dly = 0; ar_dly = 6;
    pulse_start();
    for (int c = 0; c < 500 && !axi.arvalid; c++) @(negedge clk);
    check("rdreq_reach", {31'd0, axi.arvalid}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rdreq_busy", {31'd0, busy}, 32'd1);
    check("rdreq_err", {16'd0, err_count}, 32'd0);
    wait_done();
    check_run("rdreq_start");

    run("pre_done", 4'h0, 4'h4, 4'h0, 0, 0);
    fmask = 4'h0;
    ar_dly = 0;
    pulse_start();
    check("done_clr", {31'd0, done}, 32'd0);
    check("done_errclr", {16'd0, err_count}, 32'd0);
    wait_done();
    check_run("from_done");

    bmask = 4'h1;
    rd_silent = 1'b1;
    pulse_start();
    for (int c = 0; c < 500 && !axi.rready; c++) @(negedge clk);
    check("silent_rresp", {31'd0, axi.rready}, 32'd1);
    repeat (20) @(negedge clk);
    check("silent_hold",
          {30'd0, axi.rready, busy}, 32'd3);
    check("silent_err", {16'd0, err_count}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    rd_silent = 1'b0;
    @(negedge clk);
    run("after_rst", 4'h0, 4'h0, 4'h0, 0, 0);

    for (int t = 0; t < 8; t++)
      run("rand", 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
